id_ex_control: RTL and testbench
================================

Name: id_ex_control

Overview:
- ID-stage main control decoder and ID/EX control pipeline register for the 32-bit 5-stage pipelined CPU.
- Decodes the IF/ID instruction opcode into datapath control, including the 2-bit ALU op class consumed by the EX-stage ALU control decoder: 00 lw/sw, 01 beq, 10 R-type, 11 addi.
- Registers all control, the funct field and the register indices into EX.
- Detects load-use hazards and inserts bubbles; honours downstream stall and branch flush.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr_id  in  32  instruction in IF/ID register
- valid_id  in  1  IF/ID holds a real instruction
- stall_in  in  1  downstream (MEM) stall; EX must hold
- flush  in  1  branch taken; squash ID instruction
- stall_out  out  1  hold PC and IF/ID this cycle (combinational)
- alu_op_ex  out  2  ALU op class to EX
- funct_ex  out  6  instr[5:0] registered
- rs_ex, rt_ex, rd_ex  out  5 each  register indices registered
- reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex, alu_src_ex, reg_dst_ex, branch_ex  out  1 each  registered control
- illegal  out  1  sticky: unknown opcode decoded while valid

Behaviour:
- Decode table (reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch, alu_op):
  - R-type: 1,0,0,0,0,1,0,10
  - lw: 1,1,0,1,1,0,0,00
  - sw: 0,0,1,0,1,0,0,00
  - beq: 0,0,0,0,0,0,1,01
  - addi: 1,0,0,0,1,0,0,11
- Bubble: all 1-bit controls 0, alu_op 10, funct 000000 (SLL = NOP), rs/rt/rd 0.
- Bubble sources: unknown opcode; valid_id=0. An unknown opcode with valid_id=1 also sets illegal. illegal clears only on reset.
- Load-use hazard (combinational):
  - Condition: mem_read_ex=1, rt_ex!=0, and rt_ex equals a source register of the ID instruction.
  - Source registers: rs for all classes; rt also for R-type, sw and beq.
  - Never raised when valid_id=0.
- Per-cycle priority at the clock edge:
  1. reset: all outputs as bubble, illegal=0, stall_out=0.
  2. flush: load bubble into EX; stall_out=0.
  3. stall_in: hold all EX registers unchanged; stall_out=1.
  4. load-use hazard: load bubble; stall_out=1.
  5. otherwise: load the decoded instruction.
- Latency: 1 cycle from instr_id to *_ex.
- A load-use stall lasts exactly one cycle. The following cycle mem_read_ex=0 (bubble), so the same ID instruction then proceeds.
- Back-to-back lw with a dependent third instruction yields a single one-cycle stall per dependency.
- Reset mid-stall drops any pending bubble and hold state. stall_out is 0 in the reset cycle.

Optional Feature:
- Macro: HAZARD_CNT_EN.
- Defined: adds output stall_cnt [15:0].
  - Counts cycles in which a load-use bubble is inserted; saturates at 16'hFFFF.
  - Cleared by reset; not incremented when flush or stall_in has priority.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then add $3,$1,$2 (0x00221820) valid → next cycle alu_op_ex=10, funct_ex=100000, reg_write_ex=1, reg_dst_ex=1, rd_ex=3, stall_out=0.
- lw $2,0($1) then add $3,$2,$4 → stall_out=1 for exactly one cycle; EX gets bubble (funct 000000, reg_write 0), then add with rs_ex=2; stall_cnt=1 if HAZARD_CNT_EN.
- lw $0,0($1) then add $3,$0,$4 → no stall (rt=0).
- beq (opcode 000100) with stall_in=1 for 3 cycles → EX registers hold the prior instruction; stall_out=1; beq enters EX (alu_op 01, branch 1) one cycle after stall_in drops.
- flush=1 coincident with a load-use hazard → bubble, stall_out=0, stall_cnt unchanged.
- Opcode 6'b111111 valid → bubble in EX, illegal=1 and stays 1 until reset; the following addi decodes normally (alu_op 11, alu_src 1).

Source files
------------

// File: rtl/id_ex_control.sv
// ID-stage main control decoder with the ID/EX control pipeline register, load-use bubble
// insertion, downstream stall hold and branch flush. Define HAZARD_CNT_EN to add stall_cnt.
module id_ex_control #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_ADDI  = 6'b001000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_id,
   input  logic        valid_id,
   input  logic        stall_in,
   input  logic        flush,
   output logic        stall_out,
   output logic [1:0]  alu_op_ex,
   output logic [5:0]  funct_ex,
   output logic [4:0]  rs_ex,
   output logic [4:0]  rt_ex,
   output logic [4:0]  rd_ex,
   output logic        reg_write_ex,
   output logic        mem_read_ex,
   output logic        mem_write_ex,
   output logic        mem_to_reg_ex,
   output logic        alu_src_ex,
   output logic        reg_dst_ex,
   output logic        branch_ex,
`ifdef HAZARD_CNT_EN
   output logic [15:0] stall_cnt,
`endif
   output logic        illegal
);

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       reg_dst;
      logic       branch;
      logic [1:0] alu_op;
      logic [5:0] funct;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } ctrl_t;

   // Bubble decodes as SLL $0,$0,0 so the EX stage sees a harmless R-type NOP.
   localparam ctrl_t C_BUBBLE = '{
      reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
      alu_src: 1'b0, reg_dst: 1'b0, branch: 1'b0, alu_op: 2'b10,
      funct: 6'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0
   };

   logic [5:0] w_opcode;
   logic [4:0] w_rs;
   logic [4:0] w_rt;
   logic       w_known;
   logic       w_uses_rt;
   logic       w_hazard;
   ctrl_t      w_dec;
   ctrl_t      r_ex;
   logic       r_illegal;

   assign w_opcode = instr_id[31:26];
   assign w_rs     = instr_id[25:21];
   assign w_rt     = instr_id[20:16];

   always_comb begin
      w_dec      = C_BUBBLE;
      w_known    = 1'b1;
      w_uses_rt  = 1'b0;
      w_dec.funct = instr_id[5:0];
      w_dec.rs    = w_rs;
      w_dec.rt    = w_rt;
      w_dec.rd    = instr_id[15:11];
      case (w_opcode)
         OP_RTYPE: begin
            w_dec.reg_write = 1'b1;
            w_dec.reg_dst   = 1'b1;
            w_dec.alu_op    = 2'b10;
            w_uses_rt       = 1'b1;
         end
         OP_LW: begin
            w_dec.reg_write  = 1'b1;
            w_dec.mem_read   = 1'b1;
            w_dec.mem_to_reg = 1'b1;
            w_dec.alu_src    = 1'b1;
            w_dec.alu_op     = 2'b00;
         end
         OP_SW: begin
            w_dec.mem_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.alu_op    = 2'b00;
            w_uses_rt       = 1'b1;
         end
         OP_BEQ: begin
            w_dec.branch = 1'b1;
            w_dec.alu_op = 2'b01;
            w_uses_rt    = 1'b1;
         end
         OP_ADDI: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.alu_op    = 2'b11;
         end
         default: begin
            w_dec   = C_BUBBLE;
            w_known = 1'b0;
         end
      endcase
   end

   // An unknown opcode becomes a bubble anyway, so it never needs to wait on a load.
   assign w_hazard = valid_id && w_known && r_ex.mem_read && (r_ex.rt != 5'd0) &&
                     ((r_ex.rt == w_rs) || (w_uses_rt && (r_ex.rt == w_rt)));

   assign stall_out = !reset && !flush && (stall_in || w_hazard);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex      <= C_BUBBLE;
         r_illegal <= 1'b0;
      end else if (flush) begin
         r_ex <= C_BUBBLE;
      end else if (stall_in) begin
         r_ex <= r_ex;
      end else if (w_hazard) begin
         r_ex <= C_BUBBLE;
      end else if (valid_id && w_known) begin
         r_ex <= w_dec;
      end else begin
         r_ex <= C_BUBBLE;
         if (valid_id) r_illegal <= 1'b1;
      end
   end

`ifdef HAZARD_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= 16'd0;
      end else if (!flush && !stall_in && w_hazard && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

   assign alu_op_ex     = r_ex.alu_op;
   assign funct_ex      = r_ex.funct;
   assign rs_ex         = r_ex.rs;
   assign rt_ex         = r_ex.rt;
   assign rd_ex         = r_ex.rd;
   assign reg_write_ex  = r_ex.reg_write;
   assign mem_read_ex   = r_ex.mem_read;
   assign mem_write_ex  = r_ex.mem_write;
   assign mem_to_reg_ex = r_ex.mem_to_reg;
   assign alu_src_ex    = r_ex.alu_src;
   assign reg_dst_ex    = r_ex.reg_dst;
   assign branch_ex     = r_ex.branch;
   assign illegal       = r_illegal;

endmodule

// File: tb/tb_id_ex_control.sv
// Directed bench for id_ex_control: decode, load-use bubbles, stall hold, flush, illegal.
module tb_id_ex_control;

   logic        clk;
   logic        reset;
   logic [31:0] instr_id;
   logic        valid_id;
   logic        stall_in;
   logic        flush;
   logic        stall_out;
   logic [1:0]  alu_op_ex;
   logic [5:0]  funct_ex;
   logic [4:0]  rs_ex, rt_ex, rd_ex;
   logic        reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex;
   logic        alu_src_ex, reg_dst_ex, branch_ex;
   logic        illegal;
`ifdef HAZARD_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   id_ex_control dut (
      .clk(clk), .reset(reset), .instr_id(instr_id), .valid_id(valid_id),
      .stall_in(stall_in), .flush(flush), .stall_out(stall_out),
      .alu_op_ex(alu_op_ex), .funct_ex(funct_ex),
      .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
      .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
      .mem_write_ex(mem_write_ex), .mem_to_reg_ex(mem_to_reg_ex),
      .alu_src_ex(alu_src_ex), .reg_dst_ex(reg_dst_ex), .branch_ex(branch_ex),
`ifdef HAZARD_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then settle 1 time unit so registered outputs are stable.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic v);
      instr_id = ins;
      valid_id = v;
      #1;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, ".funct"}, 32'(funct_ex), 32'h0);
      check({tag, ".alu_op"}, 32'(alu_op_ex), 32'h2);
      check({tag, ".ctl"}, {25'd0, reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex,
                            alu_src_ex, reg_dst_ex, branch_ex}, 32'h0);
      check({tag, ".regs"}, {17'd0, rs_ex, rt_ex, rd_ex}, 32'h0);
   endtask

   task automatic check_cnt(input string tag, input int exp);
`ifdef HAZARD_CNT_EN
      check(tag, 32'(stall_cnt), 32'(exp));
`else
      if (exp < 0) $display("unused %s", tag);
`endif
   endtask

   initial begin
      reset = 1'b1; instr_id = 32'h0; valid_id = 1'b0; stall_in = 1'b0; flush = 1'b0;
      step(); step();
      check_bubble("reset");
      check("reset.illegal", 32'(illegal), 32'h0);
      stall_in = 1'b1;
      #1 check("reset.stall_out_masked", 32'(stall_out), 32'h0);
      check_cnt("reset.cnt", 0);
      reset = 1'b0; stall_in = 1'b0;

      // add $3,$1,$2
      drive(32'h00221820, 1'b1);
      check("add.stall_out", 32'(stall_out), 32'h0);
      step();
      check("add.alu_op", 32'(alu_op_ex), 32'h2);
      check("add.funct", 32'(funct_ex), 32'h20);
      check("add.regwr_dst", {30'd0, reg_write_ex, reg_dst_ex}, 32'h3);
      check("add.regs", {17'd0, rs_ex, rt_ex, rd_ex}, {17'd0, 5'd1, 5'd2, 5'd3});

      // lw $2,0($1) then add $3,$2,$4 -> one bubble
      drive(32'h8C220000, 1'b1);
      step();
      check("lw.ctl", {25'd0, reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex,
                       alu_src_ex, reg_dst_ex, branch_ex}, 32'b1101100);
      check("lw.alu_op", 32'(alu_op_ex), 32'h0);
      drive(32'h00441820, 1'b1);
      check("lu.stall_on", 32'(stall_out), 32'h1);
      step();
      check_bubble("lu.bubble");
      check("lu.stall_off", 32'(stall_out), 32'h0);
      check_cnt("lu.cnt", 1);
      step();
      check("lu.add_rs", 32'(rs_ex), 32'd2);
      check("lu.add_rw", 32'(reg_write_ex), 32'h1);

      // lw $0,0($1) then add $3,$0,$4 -> no stall
      drive(32'h8C200000, 1'b1);
      step();
      drive(32'h00041820, 1'b1);
      check("lw0.stall", 32'(stall_out), 32'h0);
      step();
      check("lw0.add", {16'd0, funct_ex, rs_ex, rd_ex}, {16'd0, 6'h20, 5'd0, 5'd3});
      check_cnt("lw0.cnt", 1);

      // beq held by downstream stall for 3 cycles; add $3,$0,$4 stays in EX
      drive(32'h10220005, 1'b1);
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("hold.stall_out", 32'(stall_out), 32'h1);
         step();
         check("hold.ex", {15'd0, funct_ex, rd_ex, reg_write_ex, branch_ex},
               {15'd0, 6'h20, 5'd3, 1'b1, 1'b0});
      end
      stall_in = 1'b0;
      #1 check("beq.stall_out", 32'(stall_out), 32'h0);
      step();
      check("beq.alu_op", 32'(alu_op_ex), 32'h1);
      check("beq.branch_rw", {30'd0, branch_ex, reg_write_ex}, 32'h2);

      // lw $2; lw $5,0($2); add $6,$5,$0 -> two separate one-cycle stalls
      drive(32'h8C220000, 1'b1);
      step();
      drive(32'h8C450000, 1'b1);
      check("b2b.stall1", 32'(stall_out), 32'h1);
      step();
      check("b2b.bubble1", 32'(mem_read_ex), 32'h0);
      check("b2b.free1", 32'(stall_out), 32'h0);
      step();
      check("b2b.lw2", {26'd0, mem_read_ex, rt_ex}, {26'd0, 1'b1, 5'd5});
      drive(32'h00A03020, 1'b1);
      check("b2b.stall2", 32'(stall_out), 32'h1);
      step();
      check_bubble("b2b.bubble2");
      check("b2b.free2", 32'(stall_out), 32'h0);
      step();
      check("b2b.add", {27'd0, rd_ex}, 32'd6);
      check_cnt("b2b.cnt", 3);

      // flush coincident with load-use hazard
      drive(32'h8C220000, 1'b1);
      step();
      flush = 1'b1;
      drive(32'h00441820, 1'b1);
      check("flush.stall_out", 32'(stall_out), 32'h0);
      step();
      flush = 1'b0;
      check_bubble("flush.bubble");
      check_cnt("flush.cnt", 3);

      // illegal opcode, then addi and sw decode normally
      drive(32'hFC000000, 1'b1);
      step();
      check_bubble("ill.bubble");
      check("ill.flag", 32'(illegal), 32'h1);
      drive(32'h20010005, 1'b1);
      step();
      check("addi.alu_op", 32'(alu_op_ex), 32'h3);
      check("addi.src_rw", {30'd0, alu_src_ex, reg_write_ex}, 32'h3);
      check("addi.illegal", 32'(illegal), 32'h1);
      drive(32'hAC220004, 1'b1);
      step();
      check("sw.ctl", {25'd0, reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex,
                       alu_src_ex, reg_dst_ex, branch_ex}, 32'b0010100);
      drive(32'hFC000000, 1'b0);
      step();
      check_bubble("invalid.bubble");
      check("invalid.illegal", 32'(illegal), 32'h1);

      // reset during a pending stall
      drive(32'h8C220000, 1'b1);
      step();
      drive(32'h00441820, 1'b1);
      stall_in = 1'b1;
      reset = 1'b1;
      #1 check("rst.stall_out", 32'(stall_out), 32'h0);
      step();
      check_bubble("rst.bubble");
      check("rst.illegal", 32'(illegal), 32'h0);
      check_cnt("rst.cnt", 0);
      reset = 1'b0; stall_in = 1'b0;
      #1 check("rst.after", 32'(stall_out), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
